// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the multi-cycle shift unit:
//   - default WIDTH / SHAMT_BITS
//   - shift operation encodings (SLL/SRL/SRA/ROR)
//   - controller state encodings (IDLE/SHIFT/DONE)
//   - small helpers used by the controller
// No ports (package).
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int SHAMT_BITS_DEF = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Rotates are taken modulo WIDTH, so they never saturate.
  function automatic logic op_can_saturate(input logic [1:0] op);
    return (op != SHIFT_ROR);
  endfunction

endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One log-shifter stage: Q = D shifted by 2^K with op-specific fill/wrap.
//   D    [WIDTH]      data in
//   K    [SHAMT_BITS] stage index, shift distance is 2^K (K < SHAMT_BITS)
//   OP   [2]          SLL / SRL / SRA / ROR
//   FILL [1]          bit shifted in from the left for SRA
//   Q    [WIDTH]      shifted data out
// Purely combinational. Each candidate distance is a fixed rewiring of D,
// and K only selects among them, so there is no variable-width shifter here.
// -----------------------------------------------------------------------------
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SHAMT_BITS = SHAMT_BITS_DEF
) (
  input  logic [WIDTH-1:0]      D,
  input  logic [SHAMT_BITS-1:0] K,
  input  logic [1:0]            OP,
  input  logic                  FILL,
  output logic [WIDTH-1:0]      Q
);

  logic [WIDTH-1:0] w_cand [SHAMT_BITS];

  for (genvar g = 0; g < SHAMT_BITS; g++) begin : g_dist
    localparam int S = 1 << g;
    assign w_cand[g] =
      (OP == SHIFT_SLL) ? {D[WIDTH-S-1:0], {S{1'b0}}} :
      (OP == SHIFT_SRL) ? {{S{1'b0}}, D[WIDTH-1:S]} :
      (OP == SHIFT_SRA) ? {{S{FILL}}, D[WIDTH-1:S]} :
                          {D[S-1:0], D[WIDTH-1:S]};
  end

  always_comb begin
    Q = D;
    for (int i = 0; i < SHAMT_BITS; i++) begin
      if (K == SHAMT_BITS'(i)) Q = w_cand[i];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle shift controller. It accepts one request, steps a single
// shift_stage through distances 16, 8, 4, 2, 1 (one per clock), then presents
// the result.
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   request valid            in_ready   unit can accept
//   X [WIDTH]  operand                  Y [WIDTH]  shift amount (unsigned)
//   OP [2]     SLL/SRL/SRA/ROR
//   out_valid  Z holds a result         out_ready  consumer accepts result
//   Z [WIDTH]  result                   busy       state is not IDLE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready may depend only on this unit's state, never on valid.
// While out_valid is high, Z is held until the transfer. A request offered
// while busy is not consumed and must be held by the producer.
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SHAMT_BITS = SHAMT_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [1:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             busy
);

  localparam logic [SHAMT_BITS-1:0] CNT_TOP = SHAMT_BITS'(SHAMT_BITS - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [WIDTH-1:0]      r_work;
  logic [WIDTH-1:0]      r_z;
  logic [1:0]            r_op;
  logic [SHAMT_BITS-1:0] r_amt;
  logic [SHAMT_BITS-1:0] r_cnt;
  logic                  r_sign;

  logic                  w_accept;
  logic                  w_sat;
  logic                  w_last;
  logic [SHAMT_BITS-1:0] w_amt_sh;
  logic                  w_step;
  logic [WIDTH-1:0]      w_stage_q;
  logic [WIDTH-1:0]      w_work_nxt;
  logic [WIDTH-1:0]      w_sat_val;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign w_accept = in_valid && (r_state == ST_IDLE);

  // WIDTH is 2^SHAMT_BITS, so any set bit above the amount field means
  // Y >= WIDTH.
  assign w_sat = op_can_saturate(OP) && (|Y[WIDTH-1:SHAMT_BITS]);

  assign w_sat_val = (OP == SHIFT_SRA) ? {WIDTH{X[WIDTH-1]}} : '0;

  assign w_last   = (r_cnt == '0);
  assign w_amt_sh = r_amt >> r_cnt;
  assign w_step   = w_amt_sh[0];

  shift_stage #(
    .WIDTH      (WIDTH),
    .SHAMT_BITS (SHAMT_BITS)
  ) u_stage (
    .D    (r_work),
    .K    (r_cnt),
    .OP   (r_op),
    .FILL (r_sign),
    .Q    (w_stage_q)
  );

  assign w_work_nxt = w_step ? w_stage_q : r_work;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Working registers
  // A saturated request preloads the final value with a zero amount and a
  // single remaining step. It then moves through the same last-step path as a
  // normal request, which gives it its fixed one-edge latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_z    <= '0;
      r_op   <= '0;
      r_amt  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= OP;
        r_sign <= X[WIDTH-1];
        if (w_sat) begin
          r_work <= w_sat_val;
          r_amt  <= '0;
          r_cnt  <= '0;
        end else begin
          r_work <= X;
          r_amt  <= Y[SHAMT_BITS-1:0];
          r_cnt  <= CNT_TOP;
        end
      end else if (r_state == ST_SHIFT) begin
        r_work <= w_work_nxt;
        if (w_last) r_z   <= w_work_nxt;
        else        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign Z = r_z;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed and randomized requests against a reference shift model built from
// plain SystemVerilog shift operators. Expected results are queued at accept
// and popped at the output handshake.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [1:0]   OP;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Z;
  logic         busy;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .OP        (OP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] op);
    logic signed [W-1:0] sx;
    int unsigned s;
    sx = x;
    case (op)
      2'b00:   return (y >= W) ? '0 : (x << y);
      2'b01:   return (y >= W) ? '0 : (x >> y);
      2'b10:   return (y >= W) ? {W{x[W-1]}} : W'(sx >>> y);
      default: begin
        s = y % W;
        if (s == 0) return x;
        return (x >> s) | (x << (W - s));
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [W-1:0] y, input logic [1:0] op);
    return (op != 2'b11 && y >= W) ? 1 : 5;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issue one request, check latency/status, hold off the result for
  // `hold` cycles, then take it. If `pend` is set, a follow-on request
  // (px/py/pop) is offered while the unit is busy.
  // ---------------------------------------------------------------------------
  logic [W-1:0] px, py;
  logic [1:0]   pop;

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [1:0] op, input int hold, input bit pend);
    logic [W-1:0] e;
    int lat;
    int cyc;
    e   = ref_shift(x, y, op);
    lat = ref_latency(y, op);
    exp_q.push_back(e);
    @(negedge clk);
    X = x; Y = y; OP = op; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_accept_wait"}, W'(in_ready), 1);
    @(posedge clk); #1;
    // Accept edge is edge 0. Scramble or re-offer inputs afterwards.
    if (pend) begin
      X = px; Y = py; OP = pop; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0; X = $urandom; Y = $urandom; OP = 2'($urandom);
    end
    for (int k = 1; k <= lat; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        check({tag, "_busy_phase"}, {29'd0, out_valid, busy, in_ready}, 32'b010);
      end
      @(posedge clk); #1;
    end
    check({tag, "_out_valid"}, W'(out_valid), 1);
    check({tag, "_Z"}, Z, exp_q.pop_front());
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_state"}, {29'd0, out_valid, busy, in_ready}, 32'b110);
      check({tag, "_hold_Z"}, Z, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_state"}, {29'd0, out_valid, busy, in_ready}, 32'b001);
    check({tag, "_post_Z"}, Z, e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seen_valid;
    logic [W-1:0] ry;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    X = '0; Y = '0; OP = '0;
    px = '0; py = '0; pop = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {29'd0, out_valid, busy, in_ready}, 32'b001);
    check("reset_Z", Z, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op("srl_4",     32'h8000_0000, 32'd4,  2'b01, 0, 1'b0);
    do_op("sra_4",     32'h8000_0000, 32'd4,  2'b10, 0, 1'b0);
    do_op("sra_sat",   32'h8000_0001, 32'd40, 2'b10, 0, 1'b0);
    do_op("sll_sat",   32'h1234_5678, 32'd32, 2'b00, 0, 1'b0);
    do_op("srl_sat",   32'hFFFF_FFFF, 32'd32, 2'b01, 0, 1'b0);
    do_op("sll_31",    32'h0000_0001, 32'd31, 2'b00, 0, 1'b0);
    do_op("ror_33",    32'h0000_0001, 32'd33, 2'b11, 0, 1'b0);
    do_op("sll_0",     32'hDEAD_BEEF, 32'd0,  2'b00, 0, 1'b0);
    do_op("ror_big",   32'h1234_5678, 32'hFFFF_FFE4, 2'b11, 0, 1'b0);
    // Backpressure with a request pending while busy
    px = 32'hA5A5_0F0F; py = 32'd7; pop = 2'b10;
    do_op("srl_bp",    32'hF000_0000, 32'd28, 2'b01, 3, 1'b1);
    do_op("pending",   px, py, pop, 1, 1'b0);

    // Reset mid-SHIFT abandons the operation
    @(negedge clk);
    X = 32'h0000_00FF; Y = 32'd3; OP = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", {29'd0, out_valid, busy, in_ready}, 32'b001);
    check("midrst_Z", Z, '0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    check("midrst_no_result", W'(seen_valid), 0);
    do_op("after_rst", 32'h0000_0003, 32'd1, 2'b00, 0, 1'b0);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      ry = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
      do_op("rand", W'($urandom), ry, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
